// File: rtl/seven_segment_scan_driver_pkg.sv
// seg_pkg: shared widths, blank constants and digit helpers for the scan driver
package seg_pkg;
    localparam int SEG_W = 7;
    localparam int MAX_DIGITS = 8;
    localparam int BUS_W = SEG_W * MAX_DIGITS;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = 8'hFF;
    typedef logic [BUS_W-1:0] seg_bus_t;
    typedef logic [$clog2(MAX_DIGITS)-1:0] digit_idx_t;

    function automatic logic [SEG_W-1:0] seg_slice(input seg_bus_t bus, input digit_idx_t idx);
        return bus[SEG_W * int'(idx) +: SEG_W];
    endfunction

    function automatic logic [MAX_DIGITS-1:0] digit_enable(input digit_idx_t idx);
        return ~(MAX_DIGITS'(1) << idx);
    endfunction
endpackage

// File: rtl/seven_segment_scan_driver_if.sv
// seven_segment_scan_driver_if: pattern load/enable inputs and multiplexed display outputs
interface seven_segment_scan_driver_if;
    import seg_pkg::*;
    seg_bus_t segs_in;
    logic load;
    logic en;
    logic [SEG_W-1:0] seg_out;
    logic [MAX_DIGITS-1:0] dig_out;
    logic frame_done;
    logic pending;
    modport master(output segs_in, load, en, input seg_out, dig_out, frame_done, pending);
    modport slave(input segs_in, load, en, output seg_out, dig_out, frame_done, pending);
endinterface

// File: rtl/seven_segment_scan_driver_scan_timer.sv
// scan_timer: per-slot tick and digit index counters with slot/frame/blank flags
module scan_timer
    import seg_pkg::*;
#(
    parameter int DIV = 50000,
    parameter int BLANK = 500,
    parameter int DIGITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    output digit_idx_t idx_o,
    output logic       frame_end_o,
    output logic       in_blank_o
);
    localparam int TW = $clog2(DIV);
    logic [TW-1:0] tick_q, tick_d;
    digit_idx_t idx_q, idx_d;
    logic slot_end;
    assign slot_end = en_i && tick_q == TW'(DIV - 1);
    assign frame_end_o = slot_end && idx_q == digit_idx_t'(DIGITS - 1);
    assign in_blank_o = int'(tick_q) < BLANK;
    assign idx_o = idx_q;

    // advance tick each enabled cycle, step digit at slot end, park at zero while disabled
    always_comb begin
        tick_d = slot_end ? '0 : tick_q + TW'(1);
        idx_d = frame_end_o ? '0 : slot_end ? idx_q + digit_idx_t'(1) : idx_q;
        if (!en_i) begin
            tick_d = '0;
            idx_d = '0;
        end
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            idx_q <= '0;
        end else begin
            tick_q <= tick_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver: double-buffered, blanked time-multiplexed 8-digit 7-segment driver
module seven_segment_scan_driver
    import seg_pkg::*;
#(
    parameter int DIV = 50000,
    parameter int BLANK = 500,
    parameter int DIGITS = 8
) (
    input logic clk,
    input logic reset,
    seven_segment_scan_driver_if.slave bus
);
    digit_idx_t idx;
    logic frame_end, in_blank, lit;
    seg_bus_t active_q, active_d, shadow_q, shadow_d;
    logic pending_q, pending_d, fd_q, fd_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [MAX_DIGITS-1:0] dig_q, dig_d;

    scan_timer #(.DIV(DIV), .BLANK(BLANK), .DIGITS(DIGITS)) u_timer (
        .clk(clk),
        .reset(reset),
        .en_i(bus.en),
        .idx_o(idx),
        .frame_end_o(frame_end),
        .in_blank_o(in_blank)
    );

    assign lit = bus.en && !in_blank;

    // buffer swap at frame end (a same-cycle load beats the older shadow) and output decode
    always_comb begin
        shadow_d = bus.load ? bus.segs_in : shadow_q;
        active_d = !frame_end ? active_q : bus.load ? bus.segs_in : pending_q ? shadow_q : active_q;
        pending_d = frame_end ? 1'b0 : (bus.load | pending_q);
        seg_d = lit ? seg_slice(active_q, idx) : SEG_BLANK;
        dig_d = lit ? digit_enable(idx) : DIGIT_OFF;
        fd_d = frame_end;
    end

    // state and registered outputs; reset discards any pending pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= '1;
            shadow_q <= '1;
            pending_q <= 1'b0;
            fd_q <= 1'b0;
            seg_q <= SEG_BLANK;
            dig_q <= DIGIT_OFF;
        end else begin
            active_q <= active_d;
            shadow_q <= shadow_d;
            pending_q <= pending_d;
            fd_q <= fd_d;
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign bus.seg_out = seg_q;
    assign bus.dig_out = dig_q;
    assign bus.frame_done = fd_q;
    assign bus.pending = pending_q;
endmodule
